// File: rtl/wb_sram_responder_if.sv
// Wishbone classic bus bundle between an initiator and the SRAM responder.
interface wb_sram_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic                  wb_we_i;
    logic [ADDR_WIDTH-1:0] wb_adr_i;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic [3:0]            wb_sel_i;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic                  wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_sram_responder.sv
// Wishbone classic responder for one single-port SRAM macro (port 0).
// The SRAM is driven straight from the bus while idle, so the access is
// captured on the first edge a request is seen; the ack is timed to the
// one-cycle read latency of the macro.
module wb_sram_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_sram_responder_if.slave    wb,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [3:0]            sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } state_t;

    state_t                state_reg;
    logic                  ack_reg;
    logic [DATA_WIDTH-1:0] dat_reg;
    logic                  req;

    // A strobe without an active cycle is not a request.
    assign req = wb.wb_cyc_i & wb.wb_stb_i;

    // Address, data and mask go straight through; they only matter when
    // chip select is active, which happens in IDLE alone.
    assign sram_addr0  = wb.wb_adr_i;
    assign sram_din0   = wb.wb_dat_i;
    assign sram_wmask0 = wb.wb_sel_i;

    // Chip select / write enable: only idle requests reach the SRAM, and
    // reset parks the macro regardless of bus activity.
    always_comb begin
        sram_csb0 = 1'b1;
        sram_web0 = 1'b1;
        if (!rst && state_reg == IDLE) begin
            sram_csb0 = ~req;
            sram_web0 = ~(req & wb.wb_we_i);
        end
    end

    // Handshake FSM: writes ack one cycle after capture, reads wait one
    // extra cycle for the SRAM output and latch it together with the ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
            dat_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= 1'b0;
                    if (req) begin
                        if (wb.wb_we_i) begin
                            state_reg <= ACK;
                            ack_reg   <= 1'b1;
                        end else begin
                            state_reg <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (wb.wb_cyc_i) begin
                        dat_reg   <= sram_dout0;
                        state_reg <= ACK;
                        ack_reg   <= 1'b1;
                    end else begin
                        // Master abandoned the cycle: no ack, keep old data.
                        state_reg <= IDLE;
                        ack_reg   <= 1'b0;
                    end
                end
                ACK: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign wb.wb_ack_o = ack_reg;
    assign wb.wb_dat_o = dat_reg;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Bench for wb_sram_responder: behavioural SRAM macro, directed vector
// table, hand-written abort/ignore/reset sequences and random traffic
// checked against a word-array reference memory.
module tb_wb_sram_responder;

    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sram_csb0;
    logic          sram_web0;
    logic [3:0]    sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;

    wb_sram_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    wb_sram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (bus),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro: inputs captured at posedge, dout valid next cycle.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) sram_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
            end else begin
                sram_dout0 <= sram_mem[sram_addr0];
            end
        end
    end

    // Reference model: plain word array plus the last completed read word.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_dat_o;

    int total = 0;
    int bad   = 0;
    int txn_no = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drop_bus();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    // One bus transaction: request in cycle 0, wait (bounded) for ack,
    // checking that the SRAM is selected in cycle 0 only and ack is a pulse.
    task automatic do_txn(input bit we, input logic [8:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit scramble,
                          output int lat, output logic [31:0] rdat);
        logic nwe;
        lat  = -1;
        rdat = '0;
        nwe  = ~we;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        #1;
        chk("csb_cycle0", {31'b0, sram_csb0}, 32'd0);
        chk("web_cycle0", {31'b0, sram_web0}, {31'b0, nwe});
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("csb_busy", {31'b0, sram_csb0}, 32'd1);
            if (bus.wb_ack_o) begin
                lat  = c;
                rdat = bus.wb_dat_o;
                break;
            end
            if (scramble) begin
                bus.wb_we_i  = 1'($urandom);
                bus.wb_adr_i = 9'($urandom);
                bus.wb_dat_i = $urandom;
                bus.wb_sel_i = 4'($urandom);
            end
        end
        drop_bus();
        @(negedge clk);
        chk("ack_pulse", {31'b0, bus.wb_ack_o}, 32'd0);
    endtask

    // Transaction checked against the reference model.
    task automatic run_txn(input bit we, input logic [8:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit scramble);
        int          lat;
        logic [31:0] rdat;
        do_txn(we, adr, dat, sel, scramble, lat, rdat);
        if (we) begin
            ref_mem[adr] = merge(ref_mem[adr], dat, sel);
            chk("wr_latency", lat, 32'd1);
            chk("wr_mem", sram_mem[adr], ref_mem[adr]);
        end else begin
            chk("rd_latency", lat, 32'd2);
            chk("rd_data", rdat, ref_mem[adr]);
            exp_dat_o = ref_mem[adr];
        end
        chk("dat_o_hold", bus.wb_dat_o, exp_dat_o);
        txn_no++;
        $display("txn %0d %s adr=%h dat=%h sel=%h lat=%0d rdat=%h", txn_no,
                 we ? "WR" : "RD", adr, dat, sel, lat, rdat);
    endtask

    typedef struct {
        bit          we;
        logic [8:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;   // word stored (write) or word returned (read)
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          lat;
        logic [31:0] rdat;
        int          mem_err;

        vecs[0] = '{1'b1, 9'h1FF, 32'h12345678, 4'hF,    32'h12345678};
        vecs[1] = '{1'b1, 9'h1FF, 32'hAABBCCDD, 4'b1001, 32'hAA3456DD};
        vecs[2] = '{1'b0, 9'h1FF, 32'h0,        4'h0,    32'hAA3456DD};
        vecs[3] = '{1'b1, 9'h1FF, 32'hFFFFFFFF, 4'b0000, 32'hAA3456DD};
        vecs[4] = '{1'b0, 9'h1FF, 32'h0,        4'h5,    32'hAA3456DD};
        vecs[5] = '{1'b1, 9'h005, 32'hDEADBEEF, 4'hF,    32'hDEADBEEF};
        vecs[6] = '{1'b0, 9'h005, 32'h0,        4'h0,    32'hDEADBEEF};
        vecs[7] = '{1'b1, 9'h005, 32'h0000AB00, 4'b0010, 32'hDEADABEF};
        vecs[8] = '{1'b0, 9'h005, 32'h0,        4'h0,    32'hDEADABEF};
        vecs[9] = '{1'b1, 9'h000, 32'h0BADF00D, 4'hF,    32'h0BADF00D};

        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = $urandom;
            ref_mem[i]  = sram_mem[i];
        end
        exp_dat_o = '0;

        // Reset with a write request pending: SRAM must stay parked.
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = 9'h003;
        bus.wb_dat_i = 32'h55555555;
        bus.wb_sel_i = 4'hF;
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        chk("rst_dat", bus.wb_dat_o, 32'd0);
        chk("rst_csb", {31'b0, sram_csb0}, 32'd1);
        chk("rst_web", {31'b0, sram_web0}, 32'd1);
        drop_bus();
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, 1'b0);
            if (vecs[i].we) chk("vec_mem", sram_mem[vecs[i].adr], vecs[i].exp);
            else            chk("vec_rdat", bus.wb_dat_o, vecs[i].exp);
        end

        // Read aborted in RD_WAIT: no ack, read data untouched.
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 9'h1FF;
        @(negedge clk);
        drop_bus();
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        end
        chk("abort_dat_hold", bus.wb_dat_o, 32'hDEADABEF);
        $display("seq abort read adr=1ff dat_o=%h", bus.wb_dat_o);
        run_txn(1'b1, 9'h000, 32'hCAFEF00D, 4'hF, 1'b0);

        // Strobe without cycle is ignored.
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = 9'h003;
        bus.wb_dat_i = 32'h5A5A5A5A;
        bus.wb_sel_i = 4'hF;
        repeat (5) begin
            @(negedge clk);
            chk("stb_only_csb", {31'b0, sram_csb0}, 32'd1);
            chk("stb_only_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        end
        drop_bus();
        @(negedge clk);
        chk("stb_only_mem", sram_mem[3], ref_mem[3]);
        $display("seq stb without cyc mem[3]=%h", sram_mem[3]);

        // Reset during RD_WAIT with the request still on the bus.
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 9'h005;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        chk("mid_rst_dat", bus.wb_dat_o, 32'd0);
        chk("mid_rst_csb", {31'b0, sram_csb0}, 32'd1);
        exp_dat_o = '0;
        @(negedge clk);
        drop_bus();
        rst = 1'b0;
        $display("seq reset in RD_WAIT dat_o=%h", bus.wb_dat_o);
        run_txn(1'b0, 9'h005, 32'h0, 4'h0, 1'b0);

        // Reset while a write is being acked: ack drops, write is kept.
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = 9'h00A;
        bus.wb_dat_i = 32'h13572468;
        bus.wb_sel_i = 4'hF;
        ref_mem[10]  = 32'h13572468;
        @(negedge clk);
        chk("ack_before_rst", {31'b0, bus.wb_ack_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("ack_rst_clear", {31'b0, bus.wb_ack_o}, 32'd0);
        drop_bus();
        @(negedge clk);
        rst = 1'b0;
        $display("seq reset in ACK adr=00a");
        run_txn(1'b0, 9'h00A, 32'h0, 4'h0, 1'b0);

        // Random traffic; bus inputs scrambled while the responder is busy.
        for (int i = 0; i < 60; i++) begin
            logic [8:0] adr;
            adr = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
            run_txn(1'($urandom), adr, $urandom, 4'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        mem_err = 0;
        for (int i = 0; i < (1 << AW); i++)
            if (sram_mem[i] !== ref_mem[i]) mem_err++;
        chk("final_mem_diffs", mem_err, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
